// File: rtl/apes_rdout_sched.sv
// apes_rdout_sched -- collect/readout frame scheduler.
// Each frame clears the count datapath, counts for a programmable
// number of clk50 cycles, grants the science readout and then, if a
// housekeeping request is pending, grants the housekeeping readout.
// Optional feature: define APES_RD_TIMEOUT_EN to enable a 4096-cycle
// readout watchdog. When it is undefined, reads wait indefinitely and
// rd_timeout is tied low.
module apes_rdout_sched (
  input  logic        clk50,
  input  logic        rst,
  input  logic        enable,
  input  logic [15:0] period,
  input  logic        hk_req,
  input  logic        rdout_done,
  output logic        cnt_clr,
  output logic        cnt_start,
  output logic        sci_gnt,
  output logic        hk_gnt,
  output logic        busy,
  output logic [7:0]  frame_cnt,
  output logic        hk_ovf,
  output logic        rd_timeout
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_COLLECT = 3'd2,
    ST_SCI_RD  = 3'd3,
    ST_HK_RD   = 3'd4
  } state_t;

  state_t      r_state;
  logic [15:0] r_coll_cnt;
  logic        r_cnt_clr;
  logic        r_cnt_start;
  logic        r_sci_gnt;
  logic        r_hk_gnt;
  logic        r_busy;
  logic [7:0]  r_frame_cnt;
  logic        r_hk_pend;
  logic        r_hk_ovf;

  logic [15:0] w_period_eff;
  logic        w_in_rd;
  logic        w_wd_fire;
  logic        w_rd_end;
  logic        w_hk_entry;
  logic        w_start_run;
  logic        w_ovf_evt;

  // A zero period still collects for one cycle.
  assign w_period_eff = (period == 16'd0) ? 16'd1 : period;

  // rdout_done is only meaningful while a grant is active.
  assign w_in_rd     = (r_state == ST_SCI_RD) || (r_state == ST_HK_RD);
  assign w_rd_end    = w_in_rd && (rdout_done || w_wd_fire);

  // The clock edge that moves SCI_RD into HK_RD consumes the pending request.
  assign w_hk_entry  = (r_state == ST_SCI_RD) && w_rd_end && r_hk_pend;
  assign w_start_run = (r_state == ST_IDLE) && enable;

  // A request arriving while one is already pending is lost, unless it
  // lands exactly as the pending one is being consumed.
  assign w_ovf_evt   = hk_req && r_hk_pend && !w_hk_entry;

`ifdef APES_RD_TIMEOUT_EN
  logic [11:0] r_wd_cnt;
  logic        r_rd_timeout;

  // The watchdog fires in the 4096th consecutive read cycle without rdout_done.
  assign w_wd_fire = w_in_rd && !rdout_done && (r_wd_cnt == 12'hFFF);

  // Watchdog counter: restarts whenever a read phase begins or ends.
  always_ff @(posedge clk50 or posedge rst) begin
    if (rst) begin
      r_wd_cnt <= 12'd0;
    end else if (!w_in_rd || w_rd_end) begin
      r_wd_cnt <= 12'd0;
    end else begin
      r_wd_cnt <= r_wd_cnt + 12'd1;
    end
  end

  // Sticky timeout flag, cleared only when a new run starts from IDLE.
  always_ff @(posedge clk50 or posedge rst) begin
    if (rst) begin
      r_rd_timeout <= 1'b0;
    end else if (w_start_run) begin
      r_rd_timeout <= 1'b0;
    end else if (w_wd_fire) begin
      r_rd_timeout <= 1'b1;
    end else begin
      r_rd_timeout <= r_rd_timeout;
    end
  end

  assign rd_timeout = r_rd_timeout;
`else
  assign w_wd_fire  = 1'b0;
  assign rd_timeout = 1'b0;
`endif

  // Housekeeping pending flag and sticky overflow flag.
  always_ff @(posedge clk50 or posedge rst) begin
    if (rst) begin
      r_hk_pend <= 1'b0;
      r_hk_ovf  <= 1'b0;
    end else begin
      if (w_hk_entry) begin
        r_hk_pend <= hk_req;
      end else if (hk_req) begin
        r_hk_pend <= 1'b1;
      end else begin
        r_hk_pend <= r_hk_pend;
      end

      if (w_start_run) begin
        r_hk_ovf <= w_ovf_evt;
      end else begin
        r_hk_ovf <= r_hk_ovf | w_ovf_evt;
      end
    end
  end

  // Frame sequencer: state register plus every registered control output.
  always_ff @(posedge clk50 or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_coll_cnt  <= 16'd0;
      r_cnt_clr   <= 1'b1;
      r_cnt_start <= 1'b0;
      r_sci_gnt   <= 1'b0;
      r_hk_gnt    <= 1'b0;
      r_busy      <= 1'b0;
      r_frame_cnt <= 8'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_cnt_clr   <= 1'b1;
          r_cnt_start <= 1'b0;
          r_sci_gnt   <= 1'b0;
          r_hk_gnt    <= 1'b0;
          if (enable) begin
            r_state <= ST_CLEAR;
            r_busy  <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end

        ST_CLEAR: begin
          // period is captured here only; later changes wait for the next frame.
          r_coll_cnt  <= w_period_eff;
          r_state     <= ST_COLLECT;
          r_cnt_clr   <= 1'b0;
          r_cnt_start <= 1'b1;
          r_busy      <= 1'b1;
        end

        ST_COLLECT: begin
          if (r_coll_cnt <= 16'd1) begin
            r_state     <= ST_SCI_RD;
            r_cnt_start <= 1'b0;
            r_sci_gnt   <= 1'b1;
          end else begin
            r_coll_cnt  <= r_coll_cnt - 16'd1;
            r_cnt_start <= 1'b1;
          end
        end

        ST_SCI_RD: begin
          if (w_rd_end) begin
            r_sci_gnt <= 1'b0;
            if (r_hk_pend) begin
              r_state  <= ST_HK_RD;
              r_hk_gnt <= 1'b1;
            end else begin
              // End of frame: the readout finished without housekeeping.
              r_frame_cnt <= r_frame_cnt + 8'd1;
              r_cnt_clr   <= 1'b1;
              if (enable) begin
                r_state <= ST_CLEAR;
                r_busy  <= 1'b1;
              end else begin
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
              end
            end
          end else begin
            r_sci_gnt <= 1'b1;
          end
        end

        ST_HK_RD: begin
          if (w_rd_end) begin
            // End of frame after housekeeping readout.
            r_hk_gnt    <= 1'b0;
            r_frame_cnt <= r_frame_cnt + 8'd1;
            r_cnt_clr   <= 1'b1;
            if (enable) begin
              r_state <= ST_CLEAR;
              r_busy  <= 1'b1;
            end else begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_hk_gnt <= 1'b1;
          end
        end

        default: begin
          // Unreachable encodings recover to the safe idle state.
          r_state     <= ST_IDLE;
          r_cnt_clr   <= 1'b1;
          r_cnt_start <= 1'b0;
          r_sci_gnt   <= 1'b0;
          r_hk_gnt    <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign cnt_clr   = r_cnt_clr;
  assign cnt_start = r_cnt_start;
  assign sci_gnt   = r_sci_gnt;
  assign hk_gnt    = r_hk_gnt;
  assign busy      = r_busy;
  assign frame_cnt = r_frame_cnt;
  assign hk_ovf    = r_hk_ovf;

endmodule

// File: tb/tb_apes_rdout_sched.sv
// Testbench for apes_rdout_sched: scoreboard of expected collect lengths
// and grant order, plus direct checks of counters and sticky flags.
module tb_apes_rdout_sched;

  logic        clk50 = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] period = 16'd5;
  logic        hk_req = 1'b0;
  logic        rdout_done = 1'b0;
  logic        cnt_clr;
  logic        cnt_start;
  logic        sci_gnt;
  logic        hk_gnt;
  logic        busy;
  logic [7:0]  frame_cnt;
  logic        hk_ovf;
  logic        rd_timeout;

  int n_tests = 0;
  int n_fail = 0;
  int q_coll[$];
  int q_gnt[$];
  int overlap_cnt = 0;

  apes_rdout_sched dut (
    .clk50      (clk50),
    .rst        (rst),
    .enable     (enable),
    .period     (period),
    .hk_req     (hk_req),
    .rdout_done (rdout_done),
    .cnt_clr    (cnt_clr),
    .cnt_start  (cnt_start),
    .sci_gnt    (sci_gnt),
    .hk_gnt     (hk_gnt),
    .busy       (busy),
    .frame_cnt  (frame_cnt),
    .hk_ovf     (hk_ovf),
    .rd_timeout (rd_timeout)
  );

  always #10 clk50 = ~clk50;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk50);
    #1;
  endtask

  task automatic pulse_done();
    step();
    rdout_done = 1'b1;
    step();
    rdout_done = 1'b0;
  endtask

  task automatic pulse_hk();
    step();
    hk_req = 1'b1;
    step();
    hk_req = 1'b0;
  endtask

  // sel: 0 = sci_gnt, 1 = hk_gnt, 3 = cnt_start
  task automatic wait_cond(input int sel, input string tag);
    int   n;
    logic hit;
    n   = 0;
    hit = 1'b0;
    while (!hit && n < 200) begin
      @(negedge clk50);
      case (sel)
        0:       hit = sci_gnt;
        1:       hit = hk_gnt;
        3:       hit = cnt_start;
        default: hit = 1'b0;
      endcase
      n++;
    end
    check_eq(tag, {31'd0, hit}, 32'd1);
  endtask

  // Output monitor: measures collect runs, CLEAR length and grant order.
  int   start_run = 0;
  int   clrb_run = 0;
  logic p_start = 1'b0;
  logic p_sci = 1'b0;
  logic p_hk = 1'b0;

  always @(negedge clk50) begin
    if (rst) begin
      start_run = 0;
      clrb_run  = 0;
      p_start   = 1'b0;
      p_sci     = 1'b0;
      p_hk      = 1'b0;
    end else begin
      if (sci_gnt && hk_gnt) overlap_cnt++;

      if (cnt_start) begin
        start_run++;
      end else if (start_run > 0) begin
        if (q_coll.size() == 0) check_eq("collect_unexpected", 32'd1, 32'd0);
        else check_eq("collect_len", start_run, q_coll.pop_front());
        start_run = 0;
      end

      if (cnt_clr && busy) begin
        clrb_run++;
      end else if (clrb_run > 0) begin
        check_eq("clear_len", clrb_run, 32'd1);
        clrb_run = 0;
      end

      if (sci_gnt && !p_sci) begin
        check_eq("sci_after_collect", {31'd0, p_start}, 32'd1);
        if (q_gnt.size() == 0) check_eq("gnt_unexpected_sci", 32'd1, 32'd0);
        else check_eq("gnt_order_sci", 32'd0, q_gnt.pop_front());
      end

      if (hk_gnt && !p_hk) begin
        check_eq("hk_after_sci", {31'd0, p_sci}, 32'd1);
        if (q_gnt.size() == 0) check_eq("gnt_unexpected_hk", 32'd1, 32'd0);
        else check_eq("gnt_order_hk", 32'd1, q_gnt.pop_front());
      end

      p_start = cnt_start;
      p_sci   = sci_gnt;
      p_hk    = hk_gnt;
    end
  end

  initial begin
    int n;

    // Reset state
    repeat (3) @(posedge clk50);
    @(negedge clk50);
    check_eq("rst_cnt_clr", cnt_clr, 32'd1);
    check_eq("rst_cnt_start", cnt_start, 32'd0);
    check_eq("rst_sci_gnt", sci_gnt, 32'd0);
    check_eq("rst_hk_gnt", hk_gnt, 32'd0);
    check_eq("rst_busy", busy, 32'd0);
    check_eq("rst_frame_cnt", frame_cnt, 32'd0);
    check_eq("rst_hk_ovf", hk_ovf, 32'd0);
    check_eq("rst_rd_timeout", rd_timeout, 32'd0);
    step();
    rst = 1'b0;

    // Frame A: period 5
    q_coll.push_back(5);
    q_gnt.push_back(0);
    enable = 1'b1;
    wait_cond(0, "a_sci");
    check_eq("a_frame_cnt", frame_cnt, 32'd0);
    check_eq("a_busy", busy, 32'd1);
    period = 16'd0;
    q_coll.push_back(1);
    q_gnt.push_back(0);
    pulse_done();
    @(negedge clk50);
    check_eq("a_frame_done", frame_cnt, 32'd1);
    check_eq("a_to_clear_clr", cnt_clr, 32'd1);
    check_eq("a_to_clear_busy", busy, 32'd1);

    // Frame B: period 0 collects one cycle
    wait_cond(0, "b_sci");
    period = 16'd3;
    q_coll.push_back(3);
    q_gnt.push_back(0);
    q_gnt.push_back(1);
    pulse_done();

    // Frame C: period changed mid-collect, hk request during collect
    wait_cond(3, "c_collect");
    period = 16'd9;
    q_coll.push_back(9);
    q_gnt.push_back(0);
    q_gnt.push_back(1);
    pulse_hk();
    wait_cond(0, "c_sci");
    check_eq("c_hk_idle_in_sci", hk_gnt, 32'd0);
    pulse_done();
    wait_cond(1, "c_hk");
    check_eq("c_sci_low_in_hk", sci_gnt, 32'd0);
    check_eq("c_frame_cnt_mid", frame_cnt, 32'd2);
    pulse_done();
    @(negedge clk50);
    check_eq("c_frame_cnt", frame_cnt, 32'd3);
    check_eq("c_back_to_clear", busy, 32'd1);
    check_eq("c_hk_dropped", hk_gnt, 32'd0);
    check_eq("c_no_ovf", hk_ovf, 32'd0);

    // Frame D: two hk requests -> overflow, single hk grant, enable drops
    wait_cond(3, "d_collect");
    pulse_hk();
    pulse_hk();
    @(negedge clk50);
    check_eq("d_ovf_set", hk_ovf, 32'd1);
    wait_cond(0, "d_sci");
    enable = 1'b0;
    pulse_done();
    wait_cond(1, "d_hk");
    pulse_done();
    @(negedge clk50);
    check_eq("d_frame_cnt", frame_cnt, 32'd4);
    check_eq("d_idle_busy", busy, 32'd0);
    check_eq("d_idle_clr", cnt_clr, 32'd1);
    check_eq("d_ovf_sticky", hk_ovf, 32'd1);
    repeat (5) step();
    @(negedge clk50);
    check_eq("d_idle_hold", busy, 32'd0);
    check_eq("d_ovf_hold", hk_ovf, 32'd1);

    // Frame E: restart clears overflow; hk_req coincident with HK entry
    period = 16'd2;
    q_coll.push_back(2);
    q_gnt.push_back(0);
    q_gnt.push_back(1);
    step();
    enable = 1'b1;
    step();
    @(negedge clk50);
    check_eq("e_ovf_clr", hk_ovf, 32'd0);
    check_eq("e_busy", busy, 32'd1);
    wait_cond(3, "e_collect");
    pulse_hk();
    wait_cond(0, "e_sci");
    q_coll.push_back(2);
    q_gnt.push_back(0);
    q_gnt.push_back(1);
    step();
    rdout_done = 1'b1;
    hk_req = 1'b1;
    step();
    rdout_done = 1'b0;
    hk_req = 1'b0;
    @(negedge clk50);
    check_eq("e_hk", hk_gnt, 32'd1);
    check_eq("e_no_ovf", hk_ovf, 32'd0);
    pulse_done();

    // Frame F: re-armed request yields another hk grant
    wait_cond(0, "f_sci");
    pulse_done();
    wait_cond(1, "f_hk");
    enable = 1'b0;
    pulse_done();
    @(negedge clk50);
    check_eq("f_frame_cnt", frame_cnt, 32'd6);
    check_eq("f_idle", busy, 32'd0);
    check_eq("f_no_ovf", hk_ovf, 32'd0);

    // 250 more frames: frame_cnt wraps 255 -> 0
    period = 16'd0;
    q_coll.push_back(1);
    q_gnt.push_back(0);
    step();
    enable = 1'b1;
    for (int i = 0; i < 250; i++) begin
      wait_cond(0, "w_sci");
      if (i == 249) begin
        enable = 1'b0;
      end else begin
        q_coll.push_back(1);
        q_gnt.push_back(0);
      end
      pulse_done();
    end
    @(negedge clk50);
    check_eq("wrap_frame_cnt", frame_cnt, 32'd0);
    check_eq("wrap_idle", busy, 32'd0);

    // Readout without rdout_done
    q_coll.push_back(1);
    q_gnt.push_back(0);
    step();
    enable = 1'b1;
    wait_cond(0, "t_sci");
    enable = 1'b0;
    n = 0;
    while (sci_gnt && n < 4200) begin
      n++;
      @(negedge clk50);
    end
`ifdef APES_RD_TIMEOUT_EN
    check_eq("wd_sci_len", n, 32'd4096);
    check_eq("wd_rd_timeout", rd_timeout, 32'd1);
    check_eq("wd_frame_cnt", frame_cnt, 32'd1);
    check_eq("wd_idle", busy, 32'd0);
    q_coll.push_back(1);
    q_gnt.push_back(0);
    step();
    enable = 1'b1;
    step();
    @(negedge clk50);
    check_eq("wd_timeout_clr", rd_timeout, 32'd0);
    wait_cond(0, "r_sci");
`else
    check_eq("no_wd_sci_hold", n, 32'd4200);
    check_eq("no_wd_sci_high", sci_gnt, 32'd1);
    check_eq("no_wd_rd_timeout", rd_timeout, 32'd0);
    check_eq("no_wd_frame_cnt", frame_cnt, 32'd0);
`endif

    // Asynchronous reset during readout
    @(posedge clk50);
    #3;
    rst = 1'b1;
    #1;
    check_eq("arst_sci_gnt", sci_gnt, 32'd0);
    check_eq("arst_busy", busy, 32'd0);
    check_eq("arst_cnt_clr", cnt_clr, 32'd1);
    check_eq("arst_frame_cnt", frame_cnt, 32'd0);
    check_eq("arst_rd_timeout", rd_timeout, 32'd0);
    repeat (2) step();

    check_eq("q_coll_empty", q_coll.size(), 32'd0);
    check_eq("q_gnt_empty", q_gnt.size(), 32'd0);
    check_eq("gnt_overlap", overlap_cnt, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
